button_event_arbiter: RTL

- Collects one-cycle press pulses from up to NUM_REQ debounced buttons (P1 up/down, P2 up/down, start, pause, ...).
- Serves them one at a time to the game-logic command port over a valid/ready handshake.
- Uses round-robin priority so no button starves.
- Sits between the debouncer bank and the pong game FSM. Each press becomes exactly one command, or is flagged as an overrun when it cannot be held.

---
 rtl/button_event_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/button_event_arbiter.sv
// Purpose: round-robin arbiter turning one-cycle button press pulses into single commands for game logic.
// Latency: a press sampled at edge E0 into an idle, enabled block is offered (cmd_valid=1) after edge E1.
// Backpressure: an offer is held stable until cmd_ready; presses are kept pending, and a repeat press on a still-pending button sets a sticky overrun bit.
module button_event_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req_pulse,
    output logic               cmd_valid,
    output logic [ID_W-1:0]    cmd_id,
    input  logic               cmd_ready,
    output logic [NUM_REQ-1:0] overrun,
    input  logic               overrun_clr
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t             state_q;
    logic               cmd_valid_q;
    logic [ID_W-1:0]    cmd_id_q;
    logic [ID_W-1:0]    last_grant_q;
    logic [NUM_REQ-1:0] pending_q;
    logic [NUM_REQ-1:0] pending_d;
    logic [NUM_REQ-1:0] overrun_q;
    logic [NUM_REQ-1:0] overrun_d;

    logic               handshake;
    logic [NUM_REQ-1:0] consume_vec;
    logic [NUM_REQ-1:0] overrun_set;
    logic [ID_W-1:0]    scan_idx;
    logic [ID_W-1:0]    winner_d;
    logic               winner_found;

    // A handshake only happens while an offer is outstanding.
    assign handshake = cmd_valid_q && cmd_ready;

    // One-hot mask of the requester whose command is being accepted this cycle.
    always_comb begin
        consume_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            consume_vec[i] = handshake && (cmd_id_q == ID_W'(i));
        end
    end

    // Round-robin search over the registered pending bits, starting just after the last grant.
    always_comb begin
        scan_idx     = last_grant_q;
        winner_d     = '0;
        winner_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (scan_idx == ID_W'(NUM_REQ - 1)) ? '0 : scan_idx + 1'b1;
            if (!winner_found && pending_q[scan_idx]) begin
                winner_d     = scan_idx;
                winner_found = 1'b1;
            end
        end
    end

    // Next pending/overrun values: a new press always re-arms its bit, even when it is consumed the same cycle.
    always_comb begin
        overrun_set = req_pulse & pending_q & ~consume_vec;
        pending_d   = (pending_q & ~consume_vec) | req_pulse;
        overrun_d   = (overrun_clr ? '0 : overrun_q) | overrun_set;
    end

    // Pending and sticky overrun registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    // Offer FSM with registered command outputs; an offer is never withdrawn once made.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cmd_valid_q  <= 1'b0;
            cmd_id_q     <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable && winner_found) begin
                        cmd_id_q     <= winner_d;
                        last_grant_q <= winner_d;
                        cmd_valid_q  <= 1'b1;
                        state_q      <= OFFER;
                    end
                end
                OFFER: begin
                    if (cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    cmd_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_id    = cmd_id_q;
    assign overrun   = overrun_q;

endmodule
